intc: RTL
=========

INTC -- requirements
Module: intc

Interface
REQ-001 Parameter BASE_ADDR, default 5'h08, CSR address of register offset 0.
REQ-002 Parameter NUM_IRQS, default 8, number of interrupt sources, legal range 1..8.
REQ-003 Port clk  input  1  sole clock, all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port csr_a  input  5  CSR address, shared bus.
REQ-006 Port csr_di  input  8  CSR write data.
REQ-007 Port csr_we  input  1  CSR write strobe, one write per cycle high.
REQ-008 Port csr_do  output  8  CSR read data, registered.
REQ-009 Port src  input  NUM_IRQS  interrupt sources, synchronous to clk, e.g. gpio irq pulses.
REQ-010 Port irq  output  1  aggregated interrupt to host, active-high level, registered.

Function
REQ-011 Register map (offset from BASE_ADDR): +0 IE (rw), +1 IP (r, write-1-to-clear), +2 TYPE (rw, 1=level, 0=edge), +3 RAW (r, src_d), +4 CTRL (rw, bit0 GEN global enable, bits 7:1 read 0).
REQ-012 src SHALL be registered once into src_d; edge detect uses src & ~src_d (rising edge).
REQ-013 Edge source (TYPE bit 0): ip bit set on cycle after rising edge of src; held high src sets ip only once.
REQ-014 Level source (TYPE bit 1): ip bit set every cycle src_d is high.
REQ-015 ip bits set regardless of IE; IE masks only irq generation.
REQ-016 Write to +1: ip <= (ip & ~csr_di) | set_this_cycle; set wins over clear on same bit same cycle.
REQ-017 Level source with src still high: write-1-clear has no lasting effect; ip stays 1.
REQ-018 irq SHALL be registered: irq <= GEN & |(ie & ip), using post-update ip/ie values, i.e. irq rises 2 cycles after src rising edge (src_d, then ip, then irq = 3rd edge) -- exact: src edge at cycle N, ip=1 at N+1, irq=1 at N+2.
REQ-019 Clearing last enabled pending bit, clearing its IE bit, or clearing GEN drops irq on the cycle after ip/ie/GEN update.
REQ-020 csr_do <= selected register on every cycle (read latency 1, no read side effects); unmapped address returns 8'h00; bits >= NUM_IRQS read 0.
REQ-021 Writes to bits >= NUM_IRQS ignored; writes to unmapped or read-only (+3) addresses ignored.
REQ-022 Address decode SHALL be modulo-32 (5-bit wrap of BASE_ADDR + offset).

Reset
REQ-023 rst_n low SHALL asynchronously clear src_d, ie, ip, type, GEN, irq and csr_do to 0.
REQ-024 After rst_n release, a src already high counts as a rising edge on first clock (src_d was 0).
REQ-025 Reset mid-operation discards all pending interrupts; irq low within reset assertion, no clock needed.

Configuration
REQ-026 Macro INTC_LEVEL_EN: defined, TYPE register and level mode per REQ-014/017 present.
REQ-027 Without INTC_LEVEL_EN: no TYPE flops, +2 reads 8'h00, writes to +2 ignored, all sources edge mode.

Verification
REQ-028 Reset, no stimulus -> irq=0, reads of +0..+4 all 8'h00.
REQ-029 IE=8'h01, GEN=1, one-cycle pulse src[0] at cycle N -> ip=8'h01 at N+1, irq=1 at N+2; write +1 8'h01 -> irq=0 two cycles after write.
REQ-030 IE=8'h00, pulse src[3] -> IP reads 8'h08, irq stays 0; then write IE=8'h08 -> irq=1 on cycle after ie update.
REQ-031 Edge mode, src[2] held high 10 cycles -> ip[2] set once; clear during hold -> ip[2] stays 0 until next rising edge.
REQ-032 INTC_LEVEL_EN, TYPE=8'h02, src[1] held high, write +1 8'h02 -> IP still 8'h02, irq still 1; drop src[1] then clear -> IP 8'h00, irq 0.
REQ-033 Pulse src[0] same cycle as write +1 8'h01 -> ip[0]=1 (set wins); assert rst_n low mid-sequence -> irq and IP 0 immediately.

Source files
------------

// File: rtl/intc.sv
// intc: small interrupt controller with a byte-wide CSR port.
//   Registers at BASE_ADDR + offset (5-bit wrap):
//     +0 IE   (rw)  per-source interrupt enable, masks irq only
//     +1 IP   (r/w1c) pending bits; a set in the same cycle beats a clear
//     +2 TYPE (rw)  1 = level, 0 = edge; present only with INTC_LEVEL_EN
//     +3 RAW  (r)   registered copy of src
//     +4 CTRL (rw)  bit0 = GEN global enable
//   Optional feature macro: INTC_LEVEL_EN (TYPE register and level sources).
//   Without it, every source is rising-edge and +2 reads 8'h00.
//   CSR handshake: one write per cycle while csr_we is high; the read data
//   for the address presented in a cycle appears on csr_do after the next
//   rising edge, and reads have no side effects.
module intc #(
  parameter logic [4:0] BASE_ADDR = 5'h08,
  parameter int         NUM_IRQS  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic [NUM_IRQS-1:0] src,
  output logic                irq
);

  // Bits at or above NUM_IRQS never hold state and always read 0.
  localparam logic [7:0] IRQ_MASK = 8'((9'd1 << NUM_IRQS) - 9'd1);

  // Decode is modulo-32: the additions wrap in 5 bits.
  localparam logic [4:0] A_IE   = BASE_ADDR;
  localparam logic [4:0] A_IP   = BASE_ADDR + 5'd1;
  localparam logic [4:0] A_TYPE = BASE_ADDR + 5'd2;
  localparam logic [4:0] A_RAW  = BASE_ADDR + 5'd3;
  localparam logic [4:0] A_CTRL = BASE_ADDR + 5'd4;

  logic [7:0] src_ext;
  logic [7:0] src_d;
  logic [7:0] ie;
  logic [7:0] ip;
  logic       gen;
  logic [7:0] rise;
  logic [7:0] set_now;
  logic [7:0] ip_clr;
  logic [7:0] ip_nxt;
  logic [7:0] rd_data;
  logic       wr_ie;
  logic       wr_ip;
  logic       wr_type;
  logic       wr_ctrl;
  logic       irq_nxt;
`ifdef INTC_LEVEL_EN
  logic [7:0] type_q;
`endif

  // Source widening, edge/level set terms, write decode and pending update.
  always_comb begin
    src_ext = '0;
    for (int i = 0; i < NUM_IRQS; i++) begin
      src_ext[i] = src[i];
    end
    rise = src_ext & ~src_d;
`ifdef INTC_LEVEL_EN
    // Level sources re-assert every cycle the registered source is high.
    set_now = ((type_q & src_d) | (~type_q & rise)) & IRQ_MASK;
`else
    set_now = rise & IRQ_MASK;
`endif
    wr_ie   = csr_we && (csr_a == A_IE);
    wr_ip   = csr_we && (csr_a == A_IP);
    wr_type = csr_we && (csr_a == A_TYPE);
    wr_ctrl = csr_we && (csr_a == A_CTRL);
    ip_clr  = wr_ip ? (csr_di & IRQ_MASK) : 8'h00;
    ip_nxt  = (ip & ~ip_clr) | set_now;
    irq_nxt = gen && ((ie & ip) != 8'h00);
  end

  // Read mux; unmapped addresses return zero.
  always_comb begin
    rd_data = 8'h00;
    if (csr_a == A_IE) begin
      rd_data = ie;
    end else if (csr_a == A_IP) begin
      rd_data = ip;
    end else if (csr_a == A_TYPE) begin
`ifdef INTC_LEVEL_EN
      rd_data = type_q;
`else
      rd_data = 8'h00;
`endif
    end else if (csr_a == A_RAW) begin
      rd_data = src_d;
    end else if (csr_a == A_CTRL) begin
      rd_data = {7'd0, gen};
    end
  end

  // Source sampling register feeding edge detect and RAW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_d <= 8'h00;
    end else begin
      src_d <= src_ext;
    end
  end

  // Control registers: IE and GEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie  <= 8'h00;
      gen <= 1'b0;
    end else begin
      if (wr_ie) begin
        ie <= csr_di & IRQ_MASK;
      end
      if (wr_ctrl) begin
        gen <= csr_di[0];
      end
    end
  end

`ifdef INTC_LEVEL_EN
  // Per-source trigger type.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q <= 8'h00;
    end else if (wr_type) begin
      type_q <= csr_di & IRQ_MASK;
    end
  end
`endif

  // Pending bits: set regardless of IE, write-1-to-clear, set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip <= 8'h00;
    end else begin
      ip <= ip_nxt;
    end
  end

  // Registered host interrupt, one cycle behind the pending/enable state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_nxt;
    end
  end

  // Registered read data, refreshed every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_do <= 8'h00;
    end else begin
      csr_do <= rd_data;
    end
  end

`ifndef INTC_LEVEL_EN
  // TYPE writes have no target in the edge-only build.
  logic unused_wr_type;
  assign unused_wr_type = wr_type;
`endif

endmodule
